// File: rtl/hdp_frame_sequencer.sv
// -----------------------------------------------------------------------------
// hdp_frame_sequencer
//   Power-up/down sequencer and frame timer for an HDP panel. Pops words from a
//   show-ahead pixel FIFO and streams them to the HDP data bus as frames of
//   LINES_PER_FRAME lines. Each line has PKTS_PER_LINE data packets followed by
//   BLANK_PER_LINE blank packets. Each frame ends with BACK_PORCH idle cycles.
//   Talks to comms_master through one-cycle strobes and a completion input.
//
// Ports
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_fifoData, i_fifoEmpty   FIFO head word and empty flag (show-ahead)
//   o_fifoRead                pop strobe (combinational)
//   i_commDone                comms_master completion
//   o_commSetup/Activate/Shutdown  one-cycle request strobes
//   i_shutdown (active low)   shutdown request, honoured at frame end
//   i_wake                    restart request while OFF
//   o_lcdData, o_valid, o_update, o_sync   registered HDP bus
//   o_invert, o_nReset, o_active           panel control / status
//   o_underflow               saturating count of stalled data cycles
//   o_state                   current FSM state, for debug and checkers
//
// Handshakes: a comms request is a single-cycle strobe on the first cycle of
// its state. i_commDone is ignored in that strobe cycle and is acted on in any
// later cycle of the same state. A FIFO word is consumed exactly in the cycles
// where o_fifoRead is high. That is a data slot in NORMAL with a non-empty FIFO.
// Timed states last (wait + 1) cycles and leave when their counter reaches the wait value.
// BACK_PORCH must be at least 1.
// -----------------------------------------------------------------------------
module hdp_frame_sequencer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned PKTS_PER_LINE   = 40,
  parameter int unsigned BLANK_PER_LINE  = 4,
  parameter int unsigned LINES_PER_FRAME = 1280,
  parameter int unsigned BACK_PORCH      = 24,
  parameter int unsigned UPDATE_PKTS     = 28,
  parameter int unsigned RESET_HOLD      = 31,
  parameter int unsigned SPI_WAIT        = 1000000,
  parameter int unsigned SLEEP_WAIT      = 50000000,
  parameter int unsigned INVERT_MODE     = 0
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_fifoData,
  input  logic                  i_fifoEmpty,
  output logic                  o_fifoRead,
  input  logic                  i_commDone,
  output logic                  o_commSetup,
  output logic                  o_commActivate,
  output logic                  o_commShutdown,
  input  logic                  i_shutdown,
  input  logic                  i_wake,
  output logic [DATA_WIDTH-1:0] o_lcdData,
  output logic                  o_valid,
  output logic                  o_update,
  output logic                  o_sync,
  output logic                  o_invert,
  output logic                  o_nReset,
  output logic                  o_active,
  output logic [15:0]           o_underflow,
  output logic [3:0]            o_state
);

  localparam int unsigned SLOTS      = PKTS_PER_LINE + BLANK_PER_LINE;
  localparam int unsigned FRAME_PKTS = SLOTS * LINES_PER_FRAME;
  localparam int unsigned PW = $clog2(SLOTS + 1);
  localparam int unsigned LW = $clog2(LINES_PER_FRAME + 1);
  localparam int unsigned QW = $clog2(BACK_PORCH + 2);
  localparam int unsigned FW = $clog2(FRAME_PKTS + 1);

  typedef enum logic [3:0] {
    START        = 4'd0,
    RESET_WAIT   = 4'd1,
    SETUP        = 4'd2,
    STANDBY      = 4'd3,
    ACTIVATE     = 4'd4,
    NORMAL       = 4'd5,
    SHUTDOWN_REQ = 4'd6,
    SLEEP        = 4'd7,
    OFF          = 4'd8
  } state_t;

  state_t         state, state_next;
  logic [31:0]    cnt;
  logic [PW-1:0]  pkt;
  logic [LW-1:0]  line;
  logic [QW-1:0]  porch;
  logic           in_porch;
  logic [FW-1:0]  fidx;      // packet index within the frame, advancing slots only
  logic           shut_req;

  logic in_normal, data_slot, blank_slot, advance;
  logic last_pkt, last_line, frame_end, in_update;

  assign in_normal  = (state == NORMAL);
  assign data_slot  = in_normal && !in_porch && (pkt < PW'(PKTS_PER_LINE));
  assign blank_slot = in_normal && !in_porch && !(pkt < PW'(PKTS_PER_LINE));
  assign advance    = blank_slot || (data_slot && !i_fifoEmpty);
  assign last_pkt   = (pkt == PW'(SLOTS - 1));
  assign last_line  = (line == LW'(LINES_PER_FRAME - 1));
  assign frame_end  = in_normal && in_porch && (porch == QW'(BACK_PORCH - 1));
  assign in_update  = (32'(fidx) < UPDATE_PKTS);

  assign o_fifoRead = data_slot && !i_fifoEmpty;
  assign o_nReset   = !((state == START) || (state == OFF));
  assign o_active   = in_normal;
  assign o_state    = state;

  // State register and per-state cycle counter (cleared on every state change)
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= START;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) cnt <= '0;
      else if (cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
    end
  end

  always_comb begin
    state_next     = state;
    o_commSetup    = 1'b0;
    o_commActivate = 1'b0;
    o_commShutdown = 1'b0;
    case (state)
      START:      if (cnt == RESET_HOLD) state_next = RESET_WAIT;
      RESET_WAIT: if (cnt == SPI_WAIT) state_next = SETUP;
      SETUP: begin
        o_commSetup = (cnt == 32'd0);
        if ((cnt != 32'd0) && i_commDone) state_next = STANDBY;
      end
      STANDBY:    if (cnt == SPI_WAIT) state_next = ACTIVATE;
      ACTIVATE: begin
        o_commActivate = (cnt == 32'd0);
        if ((cnt != 32'd0) && i_commDone) state_next = NORMAL;
      end
      // The request is taken from the latch or from the current cycle's sample.
      NORMAL:     if (frame_end && (shut_req || !i_shutdown)) state_next = SHUTDOWN_REQ;
      SHUTDOWN_REQ: begin
        o_commShutdown = (cnt == 32'd0);
        if ((cnt != 32'd0) && i_commDone) state_next = SLEEP;
      end
      SLEEP:      if (cnt == SLEEP_WAIT) state_next = OFF;
      OFF:        if (i_wake) state_next = START;
      default:    state_next = START;
    endcase
  end

  // Slot counters and registered HDP bus
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      pkt         <= '0;
      line        <= '0;
      porch       <= '0;
      in_porch    <= 1'b0;
      fidx        <= '0;
      shut_req    <= 1'b0;
      o_lcdData   <= '0;
      o_valid     <= 1'b0;
      o_update    <= 1'b0;
      o_sync      <= 1'b0;
      o_invert    <= 1'b0;
      o_underflow <= '0;
    end else if (!in_normal) begin
      pkt       <= '0;
      line      <= '0;
      porch     <= '0;
      in_porch  <= 1'b0;
      fidx      <= '0;
      shut_req  <= 1'b0;
      o_lcdData <= '0;
      o_valid   <= 1'b0;
      o_update  <= 1'b0;
      o_sync    <= 1'b0;
    end else begin
      shut_req <= shut_req | !i_shutdown;
      o_valid  <= 1'b0;
      o_update <= 1'b0;
      o_sync   <= 1'b0;

      if (in_porch) begin
        o_lcdData <= '0;
        if (frame_end) begin
          in_porch <= 1'b0;
          porch    <= '0;
          fidx     <= '0;
          if (INVERT_MODE == 1) o_invert <= ~o_invert;
        end else begin
          porch <= porch + QW'(1);
        end
      end else if (data_slot) begin
        if (!i_fifoEmpty) begin
          o_lcdData <= i_fifoData;
          o_valid   <= 1'b1;
          o_update  <= in_update;
          o_sync    <= (fidx == '0);
        end else if (o_underflow != 16'hFFFF) begin
          // Stall: position and last word are held
          o_underflow <= o_underflow + 16'd1;
        end
      end else begin
        o_lcdData <= '0;
        o_update  <= in_update;
        o_sync    <= (fidx == '0);
      end

      if (advance) begin
        fidx <= fidx + FW'(1);
        if (last_pkt) begin
          pkt <= '0;
          if (last_line) begin
            line     <= '0;
            in_porch <= 1'b1;
          end else begin
            line <= line + LW'(1);
          end
        end else begin
          pkt <= pkt + PW'(1);
        end
      end
    end
  end

endmodule
